// File: rtl/axis_rgb2gray_pkg.sv
// ---------------------------------------------------------------------------
// axis_rgb2gray_pkg
//   Shared definitions for the RGB-to-luma front end. The state, status and
//   error encodings match the ones the histogram core uses, so the two blocks
//   report through one scheme.
//   Contents: FSM state enum, status codes, error codes, luma coefficients,
//   rounding constant and a zero-extending 8x8 multiply helper.
// ---------------------------------------------------------------------------
package axis_rgb2gray_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_IDLE = 2'd0;
  localparam logic [1:0] STATUS_BUSY = 2'd1;
  localparam logic [1:0] STATUS_DONE = 2'd2;
  localparam logic [1:0] STATUS_ERR  = 2'd3;

  localparam logic [1:0] ERR_NONE          = 2'd0;
  localparam logic [1:0] ERR_EARLY_TLAST   = 2'd1;
  localparam logic [1:0] ERR_MISSING_TLAST = 2'd2;

  // Y = (77R + 150G + 29B + 128) >> 8
  localparam logic [7:0]  COEF_R   = 8'd77;
  localparam logic [7:0]  COEF_G   = 8'd150;
  localparam logic [7:0]  COEF_B   = 8'd29;
  localparam logic [15:0] LUMA_RND = 16'd128;

  function automatic logic [15:0] mul8x8(input logic [7:0] a, input logic [7:0] b);
    return {8'd0, a} * {8'd0, b};
  endfunction

endpackage

// File: rtl/axis_rgb2gray_mac.sv
// ---------------------------------------------------------------------------
// rgb2y_mac
//   Two-stage luma pipeline with a global enable and valid/last sideband.
//   Stage 1 registers the three weighted channel products; stage 2 registers
//   their rounded sum, whose upper byte is the luma value.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     en                 advance both stages this cycle
//     in_valid/in_last   sideband for the beat entering stage 1
//     in_data[23:0]      {R, G, B}
//     out_valid/out_last sideband leaving stage 2
//     out_y[7:0]         luma byte
// ---------------------------------------------------------------------------
module rgb2y_mac
  import axis_rgb2gray_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [23:0] in_data,
  output logic        out_valid,
  output logic        out_last,
  output logic [7:0]  out_y
);

  // G product needs 16 bits (150*255 = 38250); all three share that width.
  logic [15:0] pr_q, pg_q, pb_q;
  logic [15:0] pr_d, pg_d, pb_d;
  logic        v1_q, l1_q;
  logic [15:0] sum_q, sum_d;
  logic        v2_q, l2_q;
  logic        unused_sum_lsbs;

  always_comb begin
    pr_d  = mul8x8(in_data[23:16], COEF_R);
    pg_d  = mul8x8(in_data[15:8],  COEF_G);
    pb_d  = mul8x8(in_data[7:0],   COEF_B);
    // Max 65408: the 16-bit sum cannot overflow.
    sum_d = pr_q + pg_q + pb_q + LUMA_RND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
    end else if (en) begin
      pr_q <= pr_d;
      pg_q <= pg_d;
      pb_q <= pb_d;
      v1_q <= in_valid;
      l1_q <= in_valid & in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
    end else if (en) begin
      sum_q <= sum_d;
      v2_q  <= v1_q;
      l2_q  <= l1_q;
    end
  end

  assign out_valid       = v2_q;
  assign out_last        = l2_q;
  assign out_y           = sum_q[15:8];
  assign unused_sum_lsbs = ^sum_q[7:0];

endmodule

// File: rtl/axis_rgb2gray.sv
// ---------------------------------------------------------------------------
// axis_rgb2gray
//   Converts a 24-bit RGB AXI-Stream frame into an 8-bit luma stream for the
//   histogram core, checking the frame length against tlast.
//   Ports:
//     clk, rst         clock, asynchronous active-high reset
//     start            begin a frame from IDLE/DONE/ERR (ignored otherwise)
//     status[1:0]      0 idle, 1 busy, 2 done, 3 error
//     err_code[1:0]    0 none, 1 early tlast, 2 missing tlast
//     s_axis_*         RGB input stream {R,G,B}
//     m_axis_*         luma output stream; tlast marks the (possibly
//                      truncated) end of frame
// ---------------------------------------------------------------------------
module axis_rgb2gray
  import axis_rgb2gray_pkg::*;
#(
  parameter int unsigned W               = 256,
  parameter int unsigned H               = 256,
  parameter int unsigned TOTAL_PIXEL     = W * H,
  parameter int unsigned TOTAL_PIXEL_BIT = $clog2(TOTAL_PIXEL)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  status,
  output logic [1:0]  err_code,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_IDX = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);

  state_e                     state_q, state_d;
  logic [TOTAL_PIXEL_BIT-1:0] cnt_q, cnt_d;
  logic [1:0]                 err_q, err_d;

  logic       en;
  logic       accept;
  logic       at_last;
  logic       term;
  logic       out_fire;
  logic       enter_run;
  logic       mac_valid;
  logic       mac_last;
  logic [7:0] mac_y;

  // Whole pipeline moves together whenever the output register can take data.
  assign en        = !mac_valid | m_axis_tready;
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign at_last   = (cnt_q == LAST_IDX);
  // Any terminating beat (tlast or final index) closes the frame downstream.
  assign term      = s_axis_tlast | at_last;
  assign out_fire  = mac_valid & m_axis_tready & mac_last;
  assign enter_run = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_RUN;
      ST_RUN:                   if (accept && term) state_d = ST_FLUSH;
      ST_FLUSH:                 if (out_fire) state_d = (err_q != ERR_NONE) ? ST_ERR : ST_DONE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    status        = STATUS_IDLE;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_RUN: begin
        status        = STATUS_BUSY;
        s_axis_tready = en;
      end
      ST_FLUSH: status = STATUS_BUSY;
      ST_DONE:  status = STATUS_DONE;
      ST_ERR:   status = STATUS_ERR;
      default:  status = STATUS_IDLE;
    endcase
  end

  // ---- pixel counter and frame check ----
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (enter_run) begin
      cnt_d = '0;
      err_d = ERR_NONE;
    end else if (accept) begin
      if (s_axis_tlast && !at_last)      err_d = ERR_EARLY_TLAST;
      else if (at_last && !s_axis_tlast) err_d = ERR_MISSING_TLAST;
      // Counter parks on the terminating index; acceptance stops there.
      if (!term) cnt_d = cnt_q + TOTAL_PIXEL_BIT'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= ERR_NONE;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_code = err_q;

  // ---- datapath ----
  rgb2y_mac u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (accept),
    .in_last   (term),
    .in_data   (s_axis_tdata),
    .out_valid (mac_valid),
    .out_last  (mac_last),
    .out_y     (mac_y)
  );

  assign m_axis_tdata  = mac_y;
  assign m_axis_tvalid = mac_valid;
  assign m_axis_tlast  = mac_last;

endmodule

// File: tb/tb_axis_rgb2gray.sv
module tb_axis_rgb2gray;

  localparam int W     = 32;
  localparam int H     = 32;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  status;
  logic [1:0]  err_code;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;

  always #5 clk = ~clk;

  axis_rgb2gray #(.W(W), .H(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .status        (status),
    .err_code      (err_code),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] pix [TOTAL];
  logic [7:0]  got [TOTAL];
  logic [8:0]  exp_q [$];
  int          first_acc;
  int          first_out;
  int          n_out;

  function automatic logic [7:0] luma(input logic [23:0] p);
    int unsigned y;
    y = (77 * 32'(p[23:16]) + 150 * 32'(p[15:8]) + 29 * 32'(p[7:0]) + 128) / 256;
    return y[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) pix[i] = 24'($urandom);
  endtask

  // Streams pix[0..nb-1] with tlast on index tl (-1: never). Returns at the
  // negedge where the terminating output handshakes, or right after beat
  // abort_at is accepted when abort_at > 0.
  task automatic run_frame(input int nb, input int tl, input int src_pct,
                           input int rdy_pct, input int abort_at, output int nout);
    int         sent;
    int         cyc;
    logic       stalled;
    logic [7:0] sd;
    logic       sl;
    logic       fin;
    logic [8:0] e;
    sent = 0; cyc = 0; stalled = 1'b0; sd = '0; sl = 1'b0; fin = 1'b0;
    nout = 0; first_acc = -1; first_out = -1;
    exp_q.delete();
    s_valid = 1'b1; s_data = pix[0]; s_last = (tl == 0); m_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    check("tready_before_run", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("status_busy", 32'(status), 32'd1);
    while (!fin && cyc < 20 * TOTAL) begin
      s_valid = (sent < nb) && ($urandom_range(99, 0) < 32'(src_pct));
      s_data  = pix[(sent < nb) ? sent : 0];
      s_last  = (sent == tl);
      m_ready = ($urandom_range(99, 0) < 32'(rdy_pct));
      @(negedge clk);
      if (stalled) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data",  32'(m_data),  32'(sd));
        check("hold_last",  32'(m_last),  32'(sl));
      end
      if (m_valid && m_ready) begin
        if (first_out < 0) first_out = cyc;
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_data), 32'(e[7:0]));
          check("out_last", 32'(m_last), 32'(e[8]));
        end
        got[nout % TOTAL] = m_data;
        nout++;
        if (m_last) fin = 1'b1;
      end
      stalled = m_valid && !m_ready;
      sd = m_data;
      sl = m_last;
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        exp_q.push_back({(s_last || sent == TOTAL - 1), luma(s_data)});
        sent++;
        if (abort_at > 0 && sent == abort_at) return;
      end
      cyc++;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    check("frame_end_seen", 32'(fin), 32'd1);
    check("model_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_status", 32'(status),   32'd0);
    check("rst_err",    32'(err_code), 32'd0);
    check("rst_mvalid", 32'(m_valid),  32'd0);
    check("rst_mdata",  32'(m_data),   32'd0);
    check("rst_mlast",  32'(m_last),   32'd0);
    check("rst_sready", 32'(s_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full white frame, no stalls
    for (int i = 0; i < TOTAL; i++) pix[i] = 24'hFFFFFF;
    run_frame(TOTAL, TOTAL - 1, 100, 100, 0, n_out);
    check("white_count", 32'(n_out), 32'(TOTAL));
    check("white_first", 32'(got[0]), 32'hFF);
    @(posedge clk); #1;
    check("white_status", 32'(status),   32'd2);
    check("white_err",    32'(err_code), 32'd0);

    // Directed pixels lead a frame started from DONE with tvalid already high
    fill_random();
    pix[0] = 24'hFF0000; pix[1] = 24'h00FF00; pix[2] = 24'h0000FF;
    pix[3] = 24'h000000; pix[4] = 24'h808080;
    run_frame(TOTAL, TOTAL - 1, 100, 100, 0, n_out);
    check("dir_red",   32'(got[0]), 32'h4D);
    check("dir_green", 32'(got[1]), 32'h95);
    check("dir_blue",  32'(got[2]), 32'h1D);
    check("dir_black", 32'(got[3]), 32'h00);
    check("dir_gray",  32'(got[4]), 32'h80);
    check("dir_latency", 32'(first_out - first_acc), 32'd2);
    @(posedge clk); #1;
    check("dir_status", 32'(status), 32'd2);

    // Random data, bursty source, 50% downstream ready
    fill_random();
    run_frame(TOTAL, TOTAL - 1, 70, 50, 0, n_out);
    check("rand_count", 32'(n_out), 32'(TOTAL));
    @(posedge clk); #1;
    check("rand_status", 32'(status),   32'd2);
    check("rand_err",    32'(err_code), 32'd0);

    // Early tlast on beat 99
    fill_random();
    run_frame(100, 99, 80, 60, 0, n_out);
    check("early_count", 32'(n_out), 32'd100);
    @(posedge clk); #1;
    check("early_status", 32'(status),   32'd3);
    check("early_err",    32'(err_code), 32'd1);
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("early_no_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;

    // Missing tlast
    fill_random();
    run_frame(TOTAL, -1, 90, 70, 0, n_out);
    check("miss_count", 32'(n_out), 32'(TOTAL));
    @(posedge clk); #1;
    check("miss_status", 32'(status),   32'd3);
    check("miss_err",    32'(err_code), 32'd2);

    // Reset mid-frame, then a clean frame
    fill_random();
    run_frame(TOTAL, TOTAL - 1, 100, 80, 300, n_out);
    rst = 1'b1;
    #1;
    check("mid_rst_mvalid", 32'(m_valid), 32'd0);
    check("mid_rst_mdata",  32'(m_data),  32'd0);
    check("mid_rst_mlast",  32'(m_last),  32'd0);
    check("mid_rst_status", 32'(status),  32'd0);
    check("mid_rst_sready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_random();
    run_frame(TOTAL, TOTAL - 1, 85, 75, 0, n_out);
    check("post_rst_count", 32'(n_out), 32'(TOTAL));
    @(posedge clk); #1;
    check("post_rst_status", 32'(status),   32'd2);
    check("post_rst_err",    32'(err_code), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
